cond_flag_unit: RTL
===================

// Module: cond_flag_unit
// PURPOSE
//  Consumer side of the ALU-decode control path. Holds the architectural NZCV
//  flags, applies the 2-bit FlagW write enables from decode and gates
//  RegWrite/MemWrite/PCSrc by the 4-bit condition field. Sits between EX and WB.
//  Flag updates pass through a one-entry pending register before commit.
// PARAMETERS
//  RESET_FLAGS  4'b0000  NZCV value loaded on reset
//  COND_W       4        condition field width (fixed encoding, do not change)
// PORTS
//  clk           in   1  system clock, rising edge
//  rst_n         in   1  reset, asynchronous assert, active-low
//  en            in   1  pipeline advance; 0 = every register holds
//  flush         in   1  kill the instruction presented this cycle
//  valid_in      in   1  instruction present at EX
//  cond          in   4  condition field
//  flag_w        in   2  [1]=write N,Z  [0]=write C,V
//  alu_flags     in   4  {N,Z,C,V} from ALU
//  pcs_in        in   1  unconditioned PCSrc
//  reg_w_in      in   1  unconditioned RegWrite
//  mem_w_in      in   1  unconditioned MemWrite
//  pc_src        out  1  registered, gated PCSrc
//  reg_write     out  1  registered, gated RegWrite
//  mem_write     out  1  registered, gated MemWrite
//  cond_ex       out  1  registered: last accepted instruction passed its condition
//  hazard_stall  out  1  combinational; upstream must hold its instruction
//  flags         out  4  committed NZCV
// BEHAVIOUR
//  - Reset: flags=RESET_FLAGS, pending invalid, all other outputs 0.
//  - Condition codes 0000..1110 = EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL.
//    1111 always evaluates false.
//  - Effective flags: eff = F merged with pending P when FLAG_FWD_EN is defined,
//    otherwise eff = F. ok = eval(cond, eff).
//  - live = valid_in & ~flush & ~hazard_stall.
//  - Each en=1 edge:
//      - If P.valid: F[3:2] <= P.val[3:2] when P.mask[1]; F[1:0] <= P.val[1:0] when P.mask[0].
//      - P <= {live & ok & |flag_w, flag_w, alu_flags}.
//      - Outputs <= {live&ok&pcs_in, live&ok&reg_w_in, live&ok&mem_w_in, live&ok}.
//  - Commit of the old P and capture of a new P in the same cycle are both legal.
//    The older update lands in F first.
//  - en=0: F, P and outputs hold. hazard_stall is still computed.
//  - flush: the current instruction becomes a bubble. P still commits, because it
//    belongs to an older instruction.
//  - Latency: gated controls one cycle after EX. Flags visible on the flags
//    output two cycles after the flag-setting instruction is at EX.
// CONFIGURATION
//  FLAG_FWD_EN defined:
//    - P is bypassed into condition evaluation.
//    - hazard_stall is tied to 0.
//    - Back-to-back flag set and conditional execute take no bubble.
//  FLAG_FWD_EN undefined:
//    - hazard_stall = valid_in & ~flush & P.valid & (cond != AL).
//    - A stalled cycle injects a bubble while P commits. The next cycle
//      evaluates against the updated F.
// STRUCTURE
//  - Package cpu_cond_pkg:
//      - enum cond_e (EQ..AL, NV)
//      - struct flags_t {n,z,c,v}
//      - localparams FW_NZ=2'b10, FW_CV=2'b01
//      - function cond_eval(cond_e, flags_t) -> logic
//  - Sub-module cond_check: combinational wrapper of cond_eval. Instantiated once.
// TESTING
//  1. Reset: rst_n=0 mid-run with P.valid.
//     -> flags=RESET_FLAGS and all outputs 0 immediately (async). P dropped.
//  2. SUBS (flag_w=11, alu_flags=0100, cond=AL), next cycle BEQ (pcs_in=1, cond=0000).
//     -> FWD_EN: pc_src=1 one cycle later.
//     -> Non-FWD: hazard_stall=1 for one cycle, then pc_src=1.
//  3. ANDS (flag_w=10, alu_flags=1010) with F=0011.
//     -> F becomes 1011 after commit (C,V preserved).
//  4. cond=NE, Z=1, reg_w_in=1, flag_w=11.
//     -> reg_write=0, cond_ex=0, F unchanged.
//  5. flush=1 with cond=AL, reg_w_in=1 while P.valid.
//     -> reg_write=0 next cycle, P commits to F.
//  6. en=0 for 3 cycles with P.valid.
//     -> F, P and outputs frozen. Commit occurs on the first en=1 edge.

Source files
------------

// File: rtl/cpu_cond_pkg.sv
// Shared types for the condition/flag path: condition encodings, the NZCV flag
// record, the gated-control bundle, and helpers for condition evaluation and flag merge.
package cpu_cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef struct packed {
    logic pc_src;
    logic reg_write;
    logic mem_write;
    logic cond_ex;
  } gated_ctl_t;

  localparam logic [1:0] FW_NZ = 2'b10;
  localparam logic [1:0] FW_CV = 2'b01;

  function automatic logic cond_eval(cond_e cond, flags_t f);
    logic r;
    r = 1'b0;
    case (cond)
      EQ: r = f.z;
      NE: r = ~f.z;
      CS: r = f.c;
      CC: r = ~f.c;
      MI: r = f.n;
      PL: r = ~f.n;
      VS: r = f.v;
      VC: r = ~f.v;
      HI: r = f.c & ~f.z;
      LS: r = ~f.c | f.z;
      GE: r = (f.n == f.v);
      LT: r = (f.n != f.v);
      GT: r = ~f.z & (f.n == f.v);
      LE: r = f.z | (f.n != f.v);
      AL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Overlay a pending update onto a flag set, field group by field group.
  function automatic flags_t merge_flags(flags_t base, logic vld, logic [1:0] mask,
                                         flags_t upd);
    flags_t r;
    r = base;
    if (vld && ((mask & FW_NZ) != 2'b00)) begin
      r.n = upd.n;
      r.z = upd.z;
    end
    if (vld && ((mask & FW_CV) != 2'b00)) begin
      r.c = upd.c;
      r.v = upd.v;
    end
    return r;
  endfunction

endpackage

// File: rtl/cond_flag_unit_if.sv
// EX-side control bundle of the condition/flag unit: decode controls in,
// gated controls, stall and committed flags out.
interface cond_flag_unit_if;
  logic       en;
  logic       flush;
  logic       valid_in;
  logic [3:0] cond;
  logic [1:0] flag_w;
  logic [3:0] alu_flags;
  logic       pcs_in;
  logic       reg_w_in;
  logic       mem_w_in;
  logic       pc_src;
  logic       reg_write;
  logic       mem_write;
  logic       cond_ex;
  logic       hazard_stall;
  logic [3:0] flags;

  modport master (
    output en, flush, valid_in, cond, flag_w, alu_flags, pcs_in, reg_w_in, mem_w_in,
    input  pc_src, reg_write, mem_write, cond_ex, hazard_stall, flags
  );

  modport slave (
    input  en, flush, valid_in, cond, flag_w, alu_flags, pcs_in, reg_w_in, mem_w_in,
    output pc_src, reg_write, mem_write, cond_ex, hazard_stall, flags
  );
endinterface

// File: rtl/cond_check.sv
// Combinational condition checker: evaluates a condition code against NZCV.
module cond_check
  import cpu_cond_pkg::*;
(
  input  cond_e  cond,
  input  flags_t flags,
  output logic   ok
);
  assign ok = cond_eval(cond, flags);
endmodule

// File: rtl/cond_flag_unit.sv
// Architectural NZCV flags with a one-entry pending update, plus condition gating
// of PCSrc/RegWrite/MemWrite. Define FLAG_FWD_EN to bypass the pending entry into evaluation.
module cond_flag_unit
  import cpu_cond_pkg::*;
#(
  parameter logic [3:0]  RESET_FLAGS = 4'b0000,
  parameter int unsigned COND_W      = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  cond_flag_unit_if.slave bus
);

  logic [COND_W-1:0] cond_raw;
  cond_e             cond_s;

  flags_t     flags_q, flags_d;
  logic       pend_vld_q, pend_vld_d;
  logic [1:0] pend_mask_q, pend_mask_d;
  flags_t     pend_val_q, pend_val_d;
  gated_ctl_t out_q, out_d;

  flags_t eff_flags;
  logic   cond_ok;
  logic   hazard;
  logic   live;
  logic   pass;

  assign cond_raw = bus.cond;
  assign cond_s   = cond_e'(cond_raw);

`ifdef FLAG_FWD_EN
  assign eff_flags = merge_flags(flags_q, pend_vld_q, pend_mask_q, pend_val_q);
  assign hazard    = 1'b0;
`else
  // Without the bypass, any conditional instruction must wait for the pending commit.
  assign eff_flags = flags_q;
  assign hazard    = bus.valid_in & ~bus.flush & pend_vld_q & (cond_s != AL);
`endif

  cond_check u_cond_check (
    .cond  (cond_s),
    .flags (eff_flags),
    .ok    (cond_ok)
  );

  assign live = bus.valid_in & ~bus.flush & ~hazard;
  assign pass = live & cond_ok;

  always_comb begin
    flags_d     = flags_q;
    pend_vld_d  = pend_vld_q;
    pend_mask_d = pend_mask_q;
    pend_val_d  = pend_val_q;
    out_d       = out_q;
    if (bus.en) begin
      // The older pending update retires into F while the new one is captured.
      flags_d         = merge_flags(flags_q, pend_vld_q, pend_mask_q, pend_val_q);
      pend_vld_d      = pass & (|bus.flag_w);
      pend_mask_d     = bus.flag_w;
      pend_val_d      = flags_t'(bus.alu_flags);
      out_d.pc_src    = pass & bus.pcs_in;
      out_d.reg_write = pass & bus.reg_w_in;
      out_d.mem_write = pass & bus.mem_w_in;
      out_d.cond_ex   = pass;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q    <= flags_t'(RESET_FLAGS);
      pend_vld_q <= 1'b0;
      out_q      <= '0;
    end else begin
      flags_q    <= flags_d;
      pend_vld_q <= pend_vld_d;
      out_q      <= out_d;
    end
  end

  // Pending payload is only meaningful while pend_vld_q is set.
  always_ff @(posedge clk) begin
    pend_mask_q <= pend_mask_d;
    pend_val_q  <= pend_val_d;
  end

  assign bus.flags        = flags_q;
  assign bus.pc_src       = out_q.pc_src;
  assign bus.reg_write    = out_q.reg_write;
  assign bus.mem_write    = out_q.mem_write;
  assign bus.cond_ex      = out_q.cond_ex;
  assign bus.hazard_stall = hazard;

endmodule
